control_unit: RTL and testbench



---
 rtl/control_unit.sv | 185 ++++++++++++++++++
 tb/tb_control_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle fetch/decode/execute sequencer for the CPU datapath
// Steps T0-T7 per instruction and decodes one control word per clock from step and opcode.
module control_unit (
    input  logic        clock,
    input  logic        clear,
    input  logic        stop,
    input  logic [31:0] ir,
    input  logic        con_ff,
    output logic        run,
    output logic [4:0]  op,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        Cout,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        Read,
    output logic        Write,
    output logic        IRin,
    output logic        Yin,
    output logic        Zlowin,
    output logic        Zhighin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        HIin,
    output logic        LOin,
    output logic        HIout,
    output logic        LOout,
    output logic        InPortout,
    output logic        OutPortin,
    output logic        CONin
);

    localparam logic [4:0] LD   = 5'b00000, LDI  = 5'b00001, ST   = 5'b00010, ADD  = 5'b00011;
    localparam logic [4:0] SUB  = 5'b00100, AND_ = 5'b00101, OR_  = 5'b00110, ROR  = 5'b00111;
    localparam logic [4:0] ROL  = 5'b01000, SHR  = 5'b01001, SHRA = 5'b01010, SHL  = 5'b01011;
    localparam logic [4:0] ADDI = 5'b01100, ANDI = 5'b01101, ORI  = 5'b01110, DIV  = 5'b01111;
    localparam logic [4:0] MUL  = 5'b10000, NEG  = 5'b10001, NOT_ = 5'b10010, BR   = 5'b10011;
    localparam logic [4:0] JR   = 5'b10100, JAL  = 5'b10101, IN_  = 5'b10110, OUT_ = 5'b10111;
    localparam logic [4:0] MFHI = 5'b11000, MFLO = 5'b11001, HALT = 5'b11011;

    typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5, T6, T7} step_t;

    step_t      step_q;
    logic       halted_q;
    logic [4:0] opc;
    step_t      last_d;
    logic       last_step;
    logic       halt_now;
    logic       unused_ir;

    assign opc       = ir[31:27];
    assign unused_ir = ^ir[26:0];

    // Final step per instruction class; fetch steps never match since every class ends at T3 or later.
    always_comb begin
        last_d = T3;
        case (opc)
            LD, ST:                                   last_d = T7;
            LDI, ADD, SUB, AND_, OR_, ROR, ROL, SHR,
            SHRA, SHL, ADDI, ANDI, ORI:               last_d = T5;
            NEG, NOT_, JAL:                           last_d = T4;
            MUL, DIV, BR:                             last_d = T6;
            default:                                  last_d = T3;
        endcase
    end

    assign last_step = (step_q == last_d);
    assign halt_now  = (step_q == T3) && (opc == HALT);

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            step_q   <= T0;
            halted_q <= 1'b0;
        end else if (!halted_q) begin
            if (halt_now || (last_step && stop)) begin
                halted_q <= 1'b1;
                step_q   <= T0;
            end else if (last_step) begin
                step_q <= T0;
            end else begin
                step_q <= step_t'(step_q + 3'd1);
            end
        end
    end

    always_comb begin
        run = 1'b0; op = 5'b00000;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0; Cout = 1'b0;
        PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0; MDRin = 1'b0; MDRout = 1'b0;
        Read = 1'b0; Write = 1'b0; IRin = 1'b0; Yin = 1'b0; Zlowin = 1'b0; Zhighin = 1'b0;
        Zlowout = 1'b0; Zhighout = 1'b0; HIin = 1'b0; LOin = 1'b0; HIout = 1'b0; LOout = 1'b0;
        InPortout = 1'b0; OutPortin = 1'b0; CONin = 1'b0;
        // Clear is gated in directly so the strobes drop without waiting for the state flops.
        if (!clear && !halted_q) begin
            run = 1'b1;
            case (step_q)
                T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
                T1: begin Read = 1'b1; MDRin = 1'b1; end
                T2: begin MDRout = 1'b1; IRin = 1'b1; end
                default: begin
                    case (opc)
                        LD, LDI, ST: begin
                            case (step_q)
                                T3: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                                T4: begin Cout = 1'b1; op = ADD; Zlowin = 1'b1; end
                                T5: begin
                                    Zlowout = 1'b1;
                                    if (opc == LDI) begin Gra = 1'b1; Rin = 1'b1; end
                                    else MARin = 1'b1;
                                end
                                T6: begin
                                    MDRin = 1'b1;
                                    if (opc == ST) begin Gra = 1'b1; Rout = 1'b1; end
                                    else Read = 1'b1;
                                end
                                T7: begin
                                    if (opc == ST) Write = 1'b1;
                                    else begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                                end
                                default: ;
                            endcase
                        end
                        ADD, SUB, AND_, OR_, ROR, ROL, SHR, SHRA, SHL, ADDI, ANDI, ORI: begin
                            case (step_q)
                                T3: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                                T4: begin
                                    Zlowin = 1'b1;
                                    case (opc)
                                        ADDI:    begin Cout = 1'b1; op = ADD; end
                                        ANDI:    begin Cout = 1'b1; op = AND_; end
                                        ORI:     begin Cout = 1'b1; op = OR_; end
                                        default: begin Grc = 1'b1; Rout = 1'b1; op = opc; end
                                    endcase
                                end
                                T5: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                                default: ;
                            endcase
                        end
                        NEG, NOT_: begin
                            if (step_q == T3) begin Grb = 1'b1; Rout = 1'b1; op = opc; Zlowin = 1'b1; end
                            else if (step_q == T4) begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        end
                        MUL, DIV: begin
                            case (step_q)
                                T3: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                                T4: begin Grb = 1'b1; Rout = 1'b1; op = opc; Zlowin = 1'b1; Zhighin = 1'b1; end
                                T5: begin Zlowout = 1'b1; LOin = 1'b1; end
                                T6: begin Zhighout = 1'b1; HIin = 1'b1; end
                                default: ;
                            endcase
                        end
                        BR: begin
                            case (step_q)
                                T3: begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                                T4: begin PCout = 1'b1; Yin = 1'b1; end
                                T5: begin Cout = 1'b1; op = ADD; Zlowin = 1'b1; end
                                T6: begin Zlowout = con_ff; PCin = con_ff; end
                                default: ;
                            endcase
                        end
                        JR:   if (step_q == T3) begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                        JAL: begin
                            if (step_q == T3) begin PCout = 1'b1; Grb = 1'b1; Rin = 1'b1; end
                            else if (step_q == T4) begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                        end
                        IN_:  if (step_q == T3) begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        OUT_: if (step_q == T3) begin Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
                        MFHI: if (step_q == T3) begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        MFLO: if (step_q == T3) begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                        default: ;
                    endcase
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - randomized check of control_unit against a per-instruction control-word model
module tb_control_unit;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        stop = 1'b0;
    logic [31:0] ir = 32'd0;
    logic        con_ff = 1'b0;
    logic        run;
    logic [4:0]  op;
    logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, PCout, PCin, IncPC, MARin, MDRin, MDRout;
    logic Read, Write, IRin, Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, HIout, LOout;
    logic InPortout, OutPortin, CONin;

    control_unit dut (
        .clock(clock), .clear(clear), .stop(stop), .ir(ir), .con_ff(con_ff), .run(run), .op(op),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout),
        .Read(Read), .Write(Write), .IRin(IRin), .Yin(Yin), .Zlowin(Zlowin), .Zhighin(Zhighin),
        .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin), .HIout(HIout),
        .LOout(LOout), .InPortout(InPortout), .OutPortin(OutPortin), .CONin(CONin)
    );

    always #5 clock = ~clock;

    localparam logic [27:0] GRA = 28'd1 << 27, GRB = 28'd1 << 26, GRC = 28'd1 << 25, RIN = 28'd1 << 24;
    localparam logic [27:0] ROUT = 28'd1 << 23, BAOUT = 28'd1 << 22, COUT = 28'd1 << 21, PCOUT = 28'd1 << 20;
    localparam logic [27:0] PCIN = 28'd1 << 19, INCPC = 28'd1 << 18, MARIN = 28'd1 << 17, MDRIN = 28'd1 << 16;
    localparam logic [27:0] MDROUT = 28'd1 << 15, READ = 28'd1 << 14, WRITE = 28'd1 << 13, IRIN = 28'd1 << 12;
    localparam logic [27:0] YIN = 28'd1 << 11, ZLOWIN = 28'd1 << 10, ZHIGHIN = 28'd1 << 9, ZLOWOUT = 28'd1 << 8;
    localparam logic [27:0] ZHIGHOUT = 28'd1 << 7, HIIN = 28'd1 << 6, LOIN = 28'd1 << 5, HIOUT = 28'd1 << 4;
    localparam logic [27:0] LOOUT = 28'd1 << 3, INPORTOUT = 28'd1 << 2, OUTPORTIN = 28'd1 << 1, CONIN = 28'd1;

    wire [33:0] obs = {run, op, Gra, Grb, Grc, Rin, Rout, BAout, Cout, PCout, PCin, IncPC, MARin,
                       MDRin, MDRout, Read, Write, IRin, Yin, Zlowin, Zhighin, Zlowout, Zhighout,
                       HIin, LOin, HIout, LOout, InPortout, OutPortin, CONin};

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];

    task automatic check(input string tag, input logic [33:0] got, input logic [33:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [4:0] o, input logic [27:0] c);
        exp_q.push_back({o, c});
    endtask

    // Sequence of control words an instruction should produce, fetch included.
    task automatic build(input logic [4:0] opc, input logic con6);
        exp_q.delete();
        push(5'd0, PCOUT | MARIN | INCPC);
        push(5'd0, READ | MDRIN);
        push(5'd0, MDROUT | IRIN);
        if (opc >= 5'd3 && opc <= 5'd11) begin
            push(5'd0, GRB | ROUT | YIN);
            push(opc, GRC | ROUT | ZLOWIN);
            push(5'd0, ZLOWOUT | GRA | RIN);
        end else if (opc >= 5'd12 && opc <= 5'd14) begin
            push(5'd0, GRB | ROUT | YIN);
            push(opc == 5'd12 ? 5'd3 : (opc == 5'd13 ? 5'd5 : 5'd6), COUT | ZLOWIN);
            push(5'd0, ZLOWOUT | GRA | RIN);
        end else if (opc == 5'd17 || opc == 5'd18) begin
            push(opc, GRB | ROUT | ZLOWIN);
            push(5'd0, ZLOWOUT | GRA | RIN);
        end else if (opc == 5'd15 || opc == 5'd16) begin
            push(5'd0, GRA | ROUT | YIN);
            push(opc, GRB | ROUT | ZLOWIN | ZHIGHIN);
            push(5'd0, ZLOWOUT | LOIN);
            push(5'd0, ZHIGHOUT | HIIN);
        end else if (opc <= 5'd2) begin
            push(5'd0, GRB | BAOUT | YIN);
            push(5'd3, COUT | ZLOWIN);
            if (opc == 5'd1) push(5'd0, ZLOWOUT | GRA | RIN);
            else begin
                push(5'd0, ZLOWOUT | MARIN);
                if (opc == 5'd0) begin
                    push(5'd0, READ | MDRIN);
                    push(5'd0, MDROUT | GRA | RIN);
                end else begin
                    push(5'd0, GRA | ROUT | MDRIN);
                    push(5'd0, WRITE);
                end
            end
        end else begin
            case (opc)
                5'd19: begin
                    push(5'd0, GRA | ROUT | CONIN);
                    push(5'd0, PCOUT | YIN);
                    push(5'd3, COUT | ZLOWIN);
                    push(5'd0, con6 ? (ZLOWOUT | PCIN) : 28'd0);
                end
                5'd20: push(5'd0, GRA | ROUT | PCIN);
                5'd21: begin
                    push(5'd0, PCOUT | GRB | RIN);
                    push(5'd0, GRA | ROUT | PCIN);
                end
                5'd22: push(5'd0, INPORTOUT | GRA | RIN);
                5'd23: push(5'd0, GRA | ROUT | OUTPORTIN);
                5'd24: push(5'd0, HIOUT | GRA | RIN);
                5'd25: push(5'd0, LOOUT | GRA | RIN);
                default: push(5'd0, 28'd0);
            endcase
        end
    endtask

    // Entered just after a rising edge with clear high; leaves just after an edge with the DUT in T0.
    task automatic release_clear(input string tag);
        #2 check({tag, "_held"}, obs, 34'd0);
        @(posedge clock); #1;
        check({tag, "_held_edge"}, obs, 34'd0);
        clear = 1'b0;
    endtask

    // con_mode: 0 -> con_ff low, 1 -> high, 2 -> random each cycle. stop_from: cycle from which stop is held.
    task automatic run_instr(input logic [31:0] instr, input int con_mode, input bit stop_end,
                             input int stop_from, input int abort_at);
        logic       cons [8];
        logic       stops[8];
        int         n;
        logic [4:0] opc;
        bit         halts;
        opc = instr[31:27];
        for (int i = 0; i < 8; i++)
            cons[i] = (con_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(con_mode);
        build(opc, cons[6]);
        n = exp_q.size();
        for (int i = 0; i < 8; i++)
            stops[i] = (i >= stop_from) ? 1'b1 : ((i == n - 1) ? stop_end : 1'($urandom_range(0, 1)));
        halts = stops[n-1] || (opc == 5'd27);
        for (int i = 0; i < n; i++) begin
            ir     = (i < 3) ? $urandom : instr;
            con_ff = cons[i];
            stop   = stops[i];
            @(negedge clock);
            check($sformatf("op%0d_t%0d", opc, i), obs, {1'b1, exp_q[i]});
            if (i == abort_at) begin
                clear = 1'b1;
                #1 check($sformatf("op%0d_abort_t%0d", opc, i), obs, 34'd0);
                @(posedge clock); #1;
                release_clear("abort");
                return;
            end
            @(posedge clock); #1;
        end
        stop = 1'b0;
        if (halts) begin
            for (int k = 0; k < 2; k++) begin
                ir = $urandom; con_ff = 1'($urandom_range(0, 1));
                @(negedge clock);
                check($sformatf("op%0d_halted%0d", opc, k), obs, 34'd0);
                @(posedge clock); #1;
            end
            clear = 1'b1;
            release_clear("reclear");
        end
    endtask

    initial begin
        @(posedge clock); #1;
        release_clear("reset");
        run_instr(32'h19890000, 2, 1'b0, 99, 4);
        run_instr(32'h19890000, 2, 1'b0, 99, -1);
        run_instr({5'b10000, 27'h0123456}, 2, 1'b0, 99, -1);
        run_instr({5'b10011, 27'h0000042}, 0, 1'b0, 99, -1);
        run_instr({5'b10011, 27'h0000042}, 1, 1'b0, 99, -1);
        run_instr({5'b00010, 27'h1234567}, 2, 1'b0, 99, -1);
        run_instr({5'b00000, 27'h0777777}, 2, 1'b0, 2, -1);
        run_instr({5'b11011, 27'h0000000}, 2, 1'b0, 99, -1);
        run_instr({5'b11110, 27'h0000000}, 2, 1'b0, 99, -1);
        for (int t = 0; t < 200; t++) begin
            run_instr({5'($urandom_range(0, 31)), 27'($urandom)}, 2,
                      ($urandom_range(0, 9) == 0), 99, -1);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
